// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one packet-memory port between NUM_REQ clients.
// Optional MEM_ARB_STATS_EN adds grant and wait statistics counters.
module mem_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*4-1:0]      req_width_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [3:0]                mem_width_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grant_o,
    output logic [15:0]               stat_wait_o
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_last_gnt;
    logic [IDX_W-1:0] r_win;

    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    int                 w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic [3:0]         w_width;
    logic               w_we;
    logic [NUM_REQ-1:0] w_ack_hot;
    logic               w_last_issue;

    // Rotating priority search starting just after the last granted client
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(r_last_gnt) + i) % NUM_REQ;
            if (!w_any && req_i[w_idx]) begin
                w_any = 1'b1;
                w_win = IDX_W'(w_idx);
            end
        end
    end

    // Winner's request fields, taken only at the grant edge
    always_comb begin
        w_addr  = req_addr_i[int'(w_win)*ADDR_W +: ADDR_W];
        w_data  = req_data_i[int'(w_win)*DATA_W +: DATA_W];
        w_width = req_width_i[int'(w_win)*4 +: 4];
        w_we    = req_we_i[w_win];
    end

    assign w_ack_hot    = NUM_REQ'(1) << r_win;
    assign w_last_issue = (r_state == S_ISSUE) && (r_cnt == 4'd0);

    // Access sequencer: grant, drive the bus, pulse the ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last_gnt  <= LAST_INIT;
            r_win       <= '0;
            ack_o       <= '0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= 4'd0;
            mem_data_o  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ack_o <= '0;
                    if (w_any) begin
                        r_state     <= S_ISSUE;
                        r_win       <= w_win;
                        r_cnt       <= CNT_INIT;
                        busy_o      <= 1'b1;
                        mem_ce_o    <= 1'b1;
                        mem_we_o    <= w_we;
                        mem_addr_o  <= w_addr;
                        mem_width_o <= w_width;
                        mem_data_o  <= w_data;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_DONE;
                        ack_o       <= w_ack_hot;
                        if (!mem_we_o) begin
                            rdata_o <= mem_data_i;
                        end
                        mem_ce_o    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_width_o <= 4'd0;
                        mem_data_o  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    ack_o      <= '0;
                    busy_o     <= 1'b0;
                    r_last_gnt <= r_win;
                end
                default: begin
                    r_state  <= S_IDLE;
                    ack_o    <= '0;
                    busy_o   <= 1'b0;
                    mem_ce_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ-1:0] w_win_hot;
    logic               w_waiting;

    assign w_win_hot = w_any ? (NUM_REQ'(1) << w_win) : '0;
    assign w_waiting = (r_state != S_IDLE) ? (|req_i)
                                           : (|(req_i & ~w_win_hot));

    // Per-client completed-access counters, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant_o <= '0;
        end else if (w_last_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if ((r_win == IDX_W'(k)) &&
                    (stat_grant_o[k*16 +: 16] != 16'hFFFF)) begin
                    stat_grant_o[k*16 +: 16] <=
                        stat_grant_o[k*16 +: 16] + 16'd1;
                end
            end
        end
    end

    // Cycles in which some request is left waiting, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wait_o <= 16'd0;
        end else if (w_waiting && (stat_wait_o != 16'hFFFF)) begin
            stat_wait_o <= stat_wait_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction model plus directed vectors.
// A second instance runs with ACCESS_CYCLES=3.
module tb_mem_arbiter;

    localparam int AC = 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   cyc;
    logic done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  width [2];

    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        busy;
    logic        ce;
    logic        mwe;
    logic [31:0] maddr;
    logic [3:0]  mwidth;
    logic [31:0] mdata;
    logic [31:0] mrd;

    logic [63:0] addr_f;
    logic [63:0] wdata_f;
    logic [7:0]  width_f;
    assign addr_f  = {addr[1], addr[0]};
    assign wdata_f = {wdata[1], wdata[0]};
    assign width_f = {width[1], width[0]};

    logic [31:0] sram [16];

    function automatic logic [31:0] init_word(input int k);
        return 32'h0800_4500 + 32'((k - 1) * 256);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) sram[k] <= init_word(k);
        end else if (ce && mwe) begin
            sram[maddr[5:2]] <= mdata;
        end
    end

    assign mrd = (ce && !mwe) ? sram[maddr[5:2]] : 32'h0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_grant;
    logic [15:0] stat_wait;
    logic [31:0] stat_grant3;
    logic [15:0] stat_wait3;
`endif

    mem_arbiter #(
        .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_i(req), .req_we_i(we),
        .req_addr_i(addr_f), .req_width_i(width_f),
        .req_data_i(wdata_f),
        .ack_o(ack), .rdata_o(rdata), .busy_o(busy),
        .mem_ce_o(ce), .mem_we_o(mwe), .mem_addr_o(maddr),
        .mem_width_o(mwidth), .mem_data_o(mdata),
        .mem_data_i(mrd)
`ifdef MEM_ARB_STATS_EN
        , .stat_grant_o(stat_grant), .stat_wait_o(stat_wait)
`endif
    );

    logic [1:0]  req3;
    logic [1:0]  we3;
    logic [63:0] addr3_f;
    logic [63:0] wdata3_f;
    logic [7:0]  width3_f;
    logic [1:0]  ack3;
    logic [31:0] rdata3;
    logic        busy3;
    logic        ce3;
    logic        mwe3;
    logic [31:0] maddr3;
    logic [3:0]  mwidth3;
    logic [31:0] mdata3;
    logic [31:0] mrd3;

    assign mrd3 = {16'hCAFE, maddr3[15:0]};

    mem_arbiter #(
        .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .req_i(req3), .req_we_i(we3),
        .req_addr_i(addr3_f), .req_width_i(width3_f),
        .req_data_i(wdata3_f),
        .ack_o(ack3), .rdata_o(rdata3), .busy_o(busy3),
        .mem_ce_o(ce3), .mem_we_o(mwe3), .mem_addr_o(maddr3),
        .mem_width_o(mwidth3), .mem_data_o(mdata3),
        .mem_data_i(mrd3)
`ifdef MEM_ARB_STATS_EN
        , .stat_grant_o(stat_grant3), .stat_wait_o(stat_wait3)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Transaction model: position within the current access
    int          m_pos;
    int          m_last;
    int          m_win;
    bit          m_found;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_width;
    logic [31:0] m_sram [16];

    logic [1:0]  exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_busy;
    logic        exp_ce;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_width;
    logic [31:0] exp_data;

    task automatic bus_idle();
        exp_ce    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = 32'h0;
        exp_width = 4'h0;
        exp_data  = 32'h0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pos     = 0;
            m_last    = 1;
            m_win     = 0;
            exp_ack   = 2'b00;
            exp_rdata = 32'h0;
            exp_busy  = 1'b0;
            bus_idle();
            for (int k = 0; k < 16; k++) m_sram[k] = init_word(k);
        end else if (m_pos == 0) begin
            exp_ack = 2'b00;
            m_found = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                if (!m_found && req[(m_last + k) % 2]) begin
                    m_win   = (m_last + k) % 2;
                    m_found = 1'b1;
                end
            end
            if (m_found) begin
                m_we      = we[m_win];
                m_addr    = addr[m_win];
                m_data    = wdata[m_win];
                m_width   = width[m_win];
                m_pos     = 1;
                exp_busy  = 1'b1;
                exp_ce    = 1'b1;
                exp_we    = m_we;
                exp_addr  = m_addr;
                exp_width = m_width;
                exp_data  = m_data;
            end else begin
                exp_busy = 1'b0;
                bus_idle();
            end
        end else if (m_pos < AC) begin
            m_pos++;
        end else if (m_pos == AC) begin
            m_pos++;
            bus_idle();
            exp_ack = 2'(1 << m_win);
            if (m_we) m_sram[m_addr[5:2]] = m_data;
            else      exp_rdata = m_sram[m_addr[5:2]];
        end else begin
            m_pos    = 0;
            m_last   = m_win;
            exp_ack  = 2'b00;
            exp_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("ack",   64'(ack),    64'(exp_ack));
            chk("rdata", 64'(rdata),  64'(exp_rdata));
            chk("busy",  64'(busy),   64'(exp_busy));
            chk("ce",    64'(ce),     64'(exp_ce));
            chk("we",    64'(mwe),    64'(exp_we));
            chk("addr",  64'(maddr),  64'(exp_addr));
            chk("width", 64'(mwidth), 64'(exp_width));
            chk("wdata", 64'(mdata),  64'(exp_data));
            chk("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_ack(output logic [1:0] a, input string nm);
        bit seen;
        seen = 1'b0;
        a    = 2'b00;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ack != 2'b00) begin
                a    = ack;
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL %s: no ack within 20 cycles, ack=%b", nm, ack);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] a;
    int         prev;

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; done = 1'b0;
        rst = 1'b1; req = 2'b11; we = 2'b00;
        addr[0] = 32'd0; addr[1] = 32'd4;
        wdata[0] = 32'h0; wdata[1] = 32'h0;
        width[0] = 4'd4; width[1] = 4'd4;
        req3 = 2'b00; we3 = 2'b00;
        addr3_f = {32'd12, 32'd0};
        wdata3_f = 64'h0; width3_f = 8'h44;

        repeat (3) begin
            tick();
            chk("rst_ack",  64'(ack),  64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ce",   64'(ce),   64'd0);
        end
        rst = 1'b0;
        wait_ack(a, "t1");
        chk("t1_first_grant", 64'(a), 64'h1);
        req = 2'b00;
        tick(); tick();

        req = 2'b10; addr[1] = 32'd4; we = 2'b00;
        tick();
        chk("t2_ce",   64'(ce),    64'd1);
        chk("t2_we",   64'(mwe),   64'd0);
        chk("t2_addr", 64'(maddr), 64'd4);
        tick();
        chk("t2_ack",   64'(ack),   64'h2);
        chk("t2_rdata", 64'(rdata), 64'h0800_4500);
        req = 2'b00;

        tick();
        req = 2'b11; addr[0] = 32'd0; addr[1] = 32'd4;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, "t3");
            chk("t3_order", 64'(a), (k % 2 == 1) ? 64'h2 : 64'h1);
            if (k > 0) chk("t3_spacing", 64'(cyc - prev), 64'd3);
            prev = cyc;
        end
        req = 2'b00;

        tick();
        req = 2'b01; we[0] = 1'b1; addr[0] = 32'd8;
        wdata[0] = 32'hDEAD_BEEF; width[0] = 4'd4;
        wait_ack(a, "t4w");
        chk("t4_wack",       64'(a),     64'h1);
        chk("t4_rdata_hold", 64'(rdata), 64'h0800_4500);
        req = 2'b00; we[0] = 1'b0;
        tick();
        req = 2'b10; addr[1] = 32'd8;
        wait_ack(a, "t4r");
        chk("t4_rack",  64'(a),     64'h2);
        chk("t4_rdata", 64'(rdata), 64'hDEAD_BEEF);
        req = 2'b00;

        tick();
        req = 2'b01; addr[0] = 32'd0;
        tick();
        chk("t5_ce_issue", 64'(ce), 64'd1);
        rst = 1'b1;
        tick();
        chk("t5_ce",   64'(ce),   64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ack",  64'(ack),  64'd0);
        rst = 1'b0; req = 2'b00;
        repeat (3) begin
            tick();
            chk("t5_noack", 64'(ack), 64'd0);
        end

        req3 = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t6_ce",  64'(ce3),  64'(i <= 3));
            chk("t6_ack", 64'(ack3), (i == 4) ? 64'h2 : 64'h0);
            if (i == 4) begin
                chk("t6_rdata", 64'(rdata3), 64'hCAFE_000C);
                req3 = 2'b00;
            end
        end
`ifdef MEM_ARB_STATS_EN
        chk("t6_stat1", 64'(stat_grant3[31:16]), 64'd1);
        chk("t6_stat0", 64'(stat_grant3[15:0]),  64'd0);
`endif
        tick();
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
